control_unit: RTL and testbench

Fetch/decode/execute sequencer that drives every control input of `ALUSystem`. It consumes the 16-bit instruction register contents and the ALU `ZCNO` flags from that datapath. It produces the mux, register-file, ALU, ARF, IR and memory control lines each cycle. Together the two blocks form the complete 8-bit processor.

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/instr_decoder.sv | 27 ++
 rtl/control_unit.sv | 213 +++++++++++++++++++++
 tb/tb_control_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the fetch/decode/execute control unit: opcodes, datapath
// control codes, the sequencer state enum and small decode helpers.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_ALU = 4'h4;
    localparam logic [3:0] OP_BRA = 4'h5;
    localparam logic [3:0] OP_BEQ = 4'h6;
    localparam logic [3:0] OP_HLT = 4'h7;

    localparam logic [1:0] FS_DEC   = 2'b00;
    localparam logic [1:0] FS_INC   = 2'b01;
    localparam logic [1:0] FS_LOAD  = 2'b10;
    localparam logic [1:0] FS_CLEAR = 2'b11;

    localparam logic [1:0] ARF_PC     = 2'b00;
    localparam logic [1:0] ARF_AR     = 2'b01;
    localparam logic [1:0] ARF_SP     = 2'b10;
    localparam logic [1:0] ARF_PCPAST = 2'b11;

    localparam logic [3:0] ARF_RSEL_PC     = 4'b1000;
    localparam logic [3:0] ARF_RSEL_AR     = 4'b0100;
    localparam logic [3:0] ARF_RSEL_SP     = 4'b0010;
    localparam logic [3:0] ARF_RSEL_PCPAST = 4'b0001;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;

    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_MEM = 2'b01;
    localparam logic [1:0] MUXA_IMM = 2'b10;
    localparam logic [1:0] MUXB_IMM = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH_L = 3'd0,
        ST_FETCH_H = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    // Register 0 maps to the MSB of the register-file write enable.
    function automatic logic [3:0] rf_onehot(input logic [1:0] reg_idx);
        logic [3:0] oh;
        case (reg_idx)
            2'd0:    oh = 4'b1000;
            2'd1:    oh = 4'b0100;
            2'd2:    oh = 4'b0010;
            2'd3:    oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction field extraction, destination one-hot and
// opcode legality check.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [1:0]  rd,
    output logic [1:0]  rs1,
    output logic [1:0]  rs2,
    output logic [3:0]  alu_fn,
    output logic [3:0]  rd_onehot,
    output logic        legal
);

    logic unused_ir_s;

    assign opcode      = ir[15:12];
    assign rd          = ir[11:10];
    assign rs1         = ir[9:8];
    assign rs2         = ir[7:6];
    assign alu_fn      = ir[3:0];
    assign rd_onehot   = rf_onehot(ir[11:10]);
    assign legal       = op_is_legal(ir[15:12]);
    assign unused_ir_s = ^ir[5:4];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the ALUSystem datapath.
// Each micro-state holds for SETTLE+1 cycles; writes fire only in the last one.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_ZCNO,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic [1:0]  IR_Funsel,
    output logic        IR_Enable,
    output logic        IR_LH,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic        Halted,
    output logic        Illegal
);

    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             last_s;

    logic [3:0] opcode_s;
    logic [1:0] rd_s;
    logic [1:0] rs1_s;
    logic [1:0] rs2_s;
    logic [3:0] alu_fn_s;
    logic [3:0] rd_oh_s;
    logic       legal_s;
    logic       unused_zcno_s;

    logic [3:0] op_r;
    logic [1:0] rd_r;
    logic [1:0] rs1_r;
    logic [1:0] rs2_r;
    logic [3:0] fn_r;
    logic [3:0] rd_oh_r;

    instr_decoder u_dec (
        .ir        (IR_Out),
        .opcode    (opcode_s),
        .rd        (rd_s),
        .rs1       (rs1_s),
        .rs2       (rs2_s),
        .alu_fn    (alu_fn_s),
        .rd_onehot (rd_oh_s),
        .legal     (legal_s)
    );

    assign last_s        = (cnt_r == CNT_LAST);
    assign unused_zcno_s = ^ALU_ZCNO[2:0];

    // State register, settle counter and fields captured during DECODE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_FETCH_L;
            cnt_r   <= '0;
            op_r    <= 4'h0;
            rd_r    <= 2'd0;
            rs1_r   <= 2'd0;
            rs2_r   <= 2'd0;
            fn_r    <= 4'h0;
            rd_oh_r <= 4'b0000;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || (state_r == ST_HALT)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == ST_DECODE) begin
                op_r    <= opcode_s;
                rd_r    <= rd_s;
                rs1_r   <= rs1_s;
                rs2_r   <= rs2_s;
                fn_r    <= alu_fn_s;
                rd_oh_r <= rd_oh_s;
            end else begin
                op_r    <= op_r;
                rd_r    <= rd_r;
                rs1_r   <= rs1_r;
                rs2_r   <= rs2_r;
                fn_r    <= fn_r;
                rd_oh_r <= rd_oh_r;
            end
        end
    end

    // Next-state selection; the opcode and Z flag are only consulted in DECODE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH_L: state_nxt_s = last_s ? ST_FETCH_H : ST_FETCH_L;
            ST_FETCH_H: state_nxt_s = last_s ? ST_DECODE : ST_FETCH_H;
            ST_DECODE: begin
                if (!legal_s) begin
                    state_nxt_s = ST_FETCH_L;
                end else begin
                    case (opcode_s)
                        OP_HLT:  state_nxt_s = ST_HALT;
                        OP_NOP:  state_nxt_s = ST_FETCH_L;
                        OP_BEQ:  state_nxt_s = ALU_ZCNO[3] ? ST_EXEC : ST_FETCH_L;
                        default: state_nxt_s = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC:    state_nxt_s = last_s ? ST_FETCH_L : ST_EXEC;
            ST_HALT:    state_nxt_s = ST_HALT;
            default:    state_nxt_s = ST_FETCH_L;
        endcase
    end

    // Moore output decode; Reset forces every control line to its idle value.
    always_comb begin
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 2'b00;
        RF_TSel     = 4'b0000;
        RF_RSel     = 4'b0000;
        ALU_FunSel  = 4'b0000;
        ARF_OutASel = 2'b00;
        ARF_OutBSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RSel    = 4'b0000;
        IR_Funsel   = 2'b00;
        IR_Enable   = 1'b0;
        IR_LH       = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        Halted      = 1'b0;
        Illegal     = 1'b0;
        if (Reset) begin
            Mem_CS = 1'b1;
        end else begin
            case (state_r)
                ST_FETCH_L, ST_FETCH_H: begin
                    ARF_OutBSel = ARF_PC;
                    Mem_CS      = 1'b0;
                    IR_LH       = (state_r == ST_FETCH_H);
                    IR_Funsel   = FS_LOAD;
                    IR_Enable   = last_s;
                    ARF_RSel    = last_s ? ARF_RSEL_PC : 4'b0000;
                    ARF_FunSel  = last_s ? FS_INC : FS_DEC;
                end
                ST_DECODE: Illegal = ~legal_s;
                ST_EXEC: begin
                    case (op_r)
                        OP_LDI: begin
                            MuxASel   = MUXA_IMM;
                            RF_FunSel = last_s ? FS_LOAD : FS_DEC;
                            RF_RSel   = last_s ? rd_oh_r : 4'b0000;
                        end
                        OP_LD: begin
                            ARF_OutBSel = ARF_AR;
                            Mem_CS      = 1'b0;
                            MuxASel     = MUXA_MEM;
                            RF_FunSel   = last_s ? FS_LOAD : FS_DEC;
                            RF_RSel     = last_s ? rd_oh_r : 4'b0000;
                        end
                        OP_ST: begin
                            RF_OutASel  = {1'b0, rd_r};
                            MuxCSel     = 1'b0;
                            ALU_FunSel  = ALU_PASS_A;
                            ARF_OutBSel = ARF_AR;
                            Mem_CS      = 1'b0;
                            Mem_WR      = last_s;
                        end
                        OP_ALU: begin
                            RF_OutASel = {1'b0, rs1_r};
                            RF_OutBSel = {1'b0, rs2_r};
                            MuxCSel    = 1'b0;
                            ALU_FunSel = fn_r;
                            MuxASel    = MUXA_ALU;
                            RF_FunSel  = last_s ? FS_LOAD : FS_DEC;
                            RF_RSel    = last_s ? rd_oh_r : 4'b0000;
                        end
                        OP_BRA, OP_BEQ: begin
                            MuxBSel    = MUXB_IMM;
                            ARF_FunSel = last_s ? FS_LOAD : FS_DEC;
                            ARF_RSel   = last_s ? ARF_RSEL_PC : 4'b0000;
                        end
                        default: MuxASel = 2'b00;
                    endcase
                end
                ST_HALT: Halted = 1'b1;
                default: Mem_CS = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction table, randomized
// instruction stream against a cycle-indexed reference model, reset/halt cases.
module tb_control_unit;

    localparam int SETTLE = 2;
    localparam int P = SETTLE + 1;

    typedef struct packed {
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic [2:0] rf_oa;
        logic [2:0] rf_ob;
        logic [1:0] rf_fs;
        logic [3:0] rf_ts;
        logic [3:0] rf_rs;
        logic [3:0] alu_fs;
        logic [1:0] arf_oa;
        logic [1:0] arf_ob;
        logic [1:0] arf_fs;
        logic [3:0] arf_rs;
        logic [1:0] ir_fs;
        logic       ir_en;
        logic       ir_lh;
        logic       mem_wr;
        logic       mem_cs;
        logic       halted;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [15:0] ir;
        logic        z;
        int          len;
        logic [1:0]  mux_a;
        logic [1:0]  mux_b;
        logic [3:0]  rf_rs;
        logic [3:0]  arf_rs;
        logic [1:0]  arf_ob;
        logic        mem_wr;
        logic        mem_cs;
        logic        ill;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IR_Out = 16'h0000;
    logic [3:0]  ALU_ZCNO = 4'h0;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_TSel, RF_RSel, ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic [1:0]  IR_Funsel;
    logic        IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal;

    int   n_vec = 0;
    int   n_err = 0;
    ctl_t last_ctl;

    control_unit #(.SETTLE(SETTLE)) dut (
        .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_ZCNO(ALU_ZCNO),
        .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_TSel(RF_TSel), .RF_RSel(RF_RSel), .ALU_FunSel(ALU_FunSel),
        .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
        .ARF_RSel(ARF_RSel), .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    function automatic ctl_t cur();
        ctl_t c;
        c = {MuxASel, MuxBSel, MuxCSel, RF_OutASel, RF_OutBSel, RF_FunSel, RF_TSel,
             RF_RSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
             IR_Funsel, IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted, Illegal};
        return c;
    endfunction

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    // Instruction length in cycles, straight from the cycle budget rules.
    function automatic int instr_len(logic [15:0] ir, logic z);
        logic [3:0] op;
        op = ir[15:12];
        if (op[3] || op == 4'h0 || (op == 4'h6 && !z)) return 2 * P + 1;
        return 3 * P + 1;
    endfunction

    // Expected outputs in cycle k (0-based) of an instruction started from fetch.
    function automatic ctl_t exp_cycle(logic [15:0] ir, logic z, int k);
        ctl_t c;
        logic [3:0] op;
        logic [3:0] rd_oh;
        logic last;
        c = idle();
        op = ir[15:12];
        rd_oh = 4'b1000 >> ir[11:10];
        last = ((k - 2 * P - 1) == P - 1);
        if (k < 2 * P) begin
            c.mem_cs = 1'b0;
            c.ir_fs = 2'b10;
            c.ir_lh = (k >= P);
            if (k % P == P - 1) begin
                c.ir_en = 1'b1;
                c.arf_rs = 4'b1000;
                c.arf_fs = 2'b01;
            end
        end else if (k == 2 * P) begin
            c.illegal = op[3];
        end else if (op == 4'h7) begin
            c.halted = 1'b1;
        end else begin
            case (op)
                4'h1: begin
                    c.mux_a = 2'b10;
                    if (last) begin c.rf_fs = 2'b10; c.rf_rs = rd_oh; end
                end
                4'h2: begin
                    c.arf_ob = 2'b01; c.mem_cs = 1'b0; c.mux_a = 2'b01;
                    if (last) begin c.rf_fs = 2'b10; c.rf_rs = rd_oh; end
                end
                4'h3: begin
                    c.rf_oa = {1'b0, ir[11:10]}; c.arf_ob = 2'b01; c.mem_cs = 1'b0;
                    c.mem_wr = last;
                end
                4'h4: begin
                    c.rf_oa = {1'b0, ir[9:8]}; c.rf_ob = {1'b0, ir[7:6]}; c.alu_fs = ir[3:0];
                    if (last) begin c.rf_fs = 2'b10; c.rf_rs = rd_oh; end
                end
                4'h5, 4'h6: begin
                    c.mux_b = 2'b10;
                    if (last) begin c.arf_fs = 2'b10; c.arf_rs = 4'b1000; end
                end
                default: c.mux_a = 2'b00;
            endcase
        end
        return c;
    endfunction

    task automatic check_ctl(input string nm, input int k, input ctl_t exp);
        ctl_t act;
        act = cur();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic check_bits(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [15:0] ir, input logic [3:0] zc);
        @(negedge Clock);
        Reset = rst;
        IR_Out = ir;
        ALU_ZCNO = zc;
        #1;
    endtask

    // Runs cycles [k0, k1) of one instruction; off-decode inputs are optionally garbage.
    task automatic run_instr(input string nm, input logic [15:0] ir, input logic z,
                             input int k0, input int k1, input bit garbage);
        for (int k = k0; k < k1; k++) begin
            if (k == 2 * P || !garbage) step(1'b0, ir, {z, 3'b000});
            else step(1'b0, 16'($urandom), 4'($urandom));
            check_ctl(nm, k, exp_cycle(ir, z, k));
            last_ctl = cur();
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h1C2A, 1'b0, 10, 2'b10, 2'b00, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h46C5, 1'b0, 10, 2'b00, 2'b00, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h6040, 1'b0, 7,  2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h6040, 1'b1, 10, 2'b00, 2'b10, 4'b0000, 4'b1000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h3000, 1'b0, 10, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'hF000, 1'b0, 7,  2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{16'h2500, 1'b0, 10, 2'b01, 2'b00, 4'b0100, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 1'b0, 7,  2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h5033, 1'b0, 10, 2'b00, 2'b10, 4'b0000, 4'b1000, 2'b00, 1'b0, 1'b1, 1'b0};

        // Reset held three cycles with outputs idle throughout.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'($urandom), 4'($urandom));
            check_ctl("reset_idle", i, idle());
        end

        // Directed table: full per-cycle model check plus last-cycle key fields.
        foreach (vecs[i]) begin
            run_instr("table", vecs[i].ir, vecs[i].z, 0, vecs[i].len, 1'b0);
            check_bits("tbl_mux_a", {2'b00, last_ctl.mux_a}, {2'b00, vecs[i].mux_a});
            check_bits("tbl_mux_b", {2'b00, last_ctl.mux_b}, {2'b00, vecs[i].mux_b});
            check_bits("tbl_rf_rsel", last_ctl.rf_rs, vecs[i].rf_rs);
            check_bits("tbl_arf_rsel", last_ctl.arf_rs, vecs[i].arf_rs);
            check_bits("tbl_arf_ob", {2'b00, last_ctl.arf_ob}, {2'b00, vecs[i].arf_ob});
            check_bits("tbl_mem", {2'b00, last_ctl.mem_wr, last_ctl.mem_cs},
                       {2'b00, vecs[i].mem_wr, vecs[i].mem_cs});
            check_bits("tbl_illegal", {3'b000, last_ctl.illegal}, {3'b000, vecs[i].ill});
        end

        // Random instruction stream; IR and flags are garbage outside DECODE.
        for (int n = 0; n < 200; n++) begin
            logic [15:0] ir;
            logic        z;
            ir = 16'($urandom);
            if (ir[15:12] == 4'h7) ir[15:12] = 4'h0;
            z = 1'($urandom);
            run_instr("random", ir, z, 0, instr_len(ir, z), 1'b1);
        end

        // Reset during the second EXEC cycle of an LDI abandons the write.
        run_instr("ldi_pre_reset", 16'h1C2A, 1'b0, 0, 2 * P + 2, 1'b0);
        step(1'b1, 16'h1C2A, 4'h0);
        check_ctl("reset_mid_exec", 0, idle());
        run_instr("after_reset", 16'h1C2A, 1'b0, 0, instr_len(16'h1C2A, 1'b0), 1'b0);

        // HLT: halted from the cycle after decode, holds until reset.
        run_instr("halt", 16'h7000, 1'b0, 0, 2 * P + 1 + 25, 1'b1);
        step(1'b1, 16'h0000, 4'h0);
        check_ctl("halt_reset", 0, idle());
        run_instr("post_halt", 16'h0000, 1'b0, 0, instr_len(16'h0000, 1'b0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
